dm_line_fill_mem: RTL and testbench

- Backing-memory responder on the miss side of the direct-mapped cache.
- Accepts refill (read-line) and write-through (single-word) requests from the cache controller.
- Returns a full cache line as an in-order burst after a fixed access latency, or acknowledges a write with a single beat.
- Also serves as the memory model behind the cache in system-level sims, with a realistic latency and handshake.

---
 rtl/dm_cache_pkg.sv | 35 +++
 rtl/dm_line_fill_mem_if.sv | 30 +++
 rtl/dm_mem_array.sv | 31 +++
 rtl/dm_line_fill_mem.sv | 155 +++++++++++++++
 tb/tb_dm_line_fill_mem.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_cache_pkg.sv
// Geometry, FSM encoding and address-split helpers shared by the direct-mapped
// cache and its line-fill memory.
package dm_cache_pkg;

    localparam int DM_ADDR_W         = 32;
    localparam int DM_DATA_W         = 32;
    localparam int DM_WORDS_PER_LINE = 4;
    localparam int DM_BYTE_OFF_W     = 2;
    localparam int DM_WORD_OFF_W     = $clog2(DM_WORDS_PER_LINE);
    localparam int DM_LINES          = 16;
    localparam int DM_INDEX_W        = $clog2(DM_LINES);
    localparam int DM_TAG_W          = DM_ADDR_W - DM_INDEX_W - DM_WORD_OFF_W - DM_BYTE_OFF_W;

    typedef logic [DM_ADDR_W-1:0] dm_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_WACK  = 2'd3
    } fill_state_e;

    function automatic logic [DM_WORD_OFF_W-1:0] addr_word_off(input dm_addr_t addr);
        return DM_WORD_OFF_W'(addr >> DM_BYTE_OFF_W);
    endfunction

    function automatic logic [DM_INDEX_W-1:0] addr_index(input dm_addr_t addr);
        return DM_INDEX_W'(addr >> (DM_BYTE_OFF_W + DM_WORD_OFF_W));
    endfunction

    function automatic logic [DM_TAG_W-1:0] addr_tag(input dm_addr_t addr);
        return DM_TAG_W'(addr >> (DM_BYTE_OFF_W + DM_WORD_OFF_W + DM_INDEX_W));
    endfunction

endpackage

// File: rtl/dm_line_fill_mem_if.sv
// Request/response handshake between the cache controller (master) and the
// line-fill memory (slave).
interface dm_line_fill_mem_if
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W,
    parameter int IDX_W  = DM_WORD_OFF_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [IDX_W-1:0]  rsp_idx;
    logic              rsp_last;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
    );
endinterface

// File: rtl/dm_mem_array.sv
// Word storage: synchronous write, combinational read, one shared address.
// Contents are not touched by reset; each word powers up holding its own byte address.
module dm_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] rd_words [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_W-1:0] word_q = DATA_W'(4 * g);

        always_ff @(posedge clk) begin
            if (we_i && (addr_i == AW'(g))) begin
                word_q <= wdata_i;
            end
        end

        assign rd_words[g] = word_q;
    end

    assign rdata_o = rd_words[addr_i];

endmodule

// File: rtl/dm_line_fill_mem.sv
// Backing-memory responder for cache misses: line-read bursts and single-word
// write acknowledges after a fixed access latency.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | req_ready=1, waiting for a request; writes commit on accept
//   ST_WAIT  | access latency down-count, request inputs ignored
//   ST_BURST | streaming the aligned line, one beat per rsp handshake
//   ST_WACK  | single acknowledge beat echoing the written word
module dm_line_fill_mem
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W         = DM_ADDR_W,
    parameter int DATA_W         = DM_DATA_W,
    parameter int WORDS_PER_LINE = DM_WORDS_PER_LINE,
    parameter int LATENCY        = 3,
    parameter int MEM_DEPTH      = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_line_fill_mem_if.slave bus
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int LINE_W = MEM_AW - OFF_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    fill_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              idle;
    logic              req_ready;
    logic              accept;
    logic [MEM_AW-1:0] req_word;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [OFF_W-1:0]  rsp_idx;
    logic              rsp_last;

    // Upper address bits alias onto the storage; byte offset is not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:MEM_AW+2], bus.req_addr[1:0]};

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = rst_n & idle;
    assign accept    = bus.req_valid & req_ready;
    assign req_word  = bus.req_addr[MEM_AW+1:2];

    // The port is shared: the request word while idle, the burst beat otherwise.
    assign mem_addr = idle ? req_word : {line_q, beat_q};

    dm_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (accept & bus.req_we),
        .addr_i  (mem_addr),
        .wdata_i (bus.req_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
            line_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            line_q  <= line_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        we_d      = we_q;
        line_d    = line_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_idx   = '0;
        rsp_last  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    line_d  = req_word[MEM_AW-1:OFF_W];
                    off_d   = req_word[OFF_W-1:0];
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_W'(LATENCY);
                    beat_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = we_q ? ST_WACK : ST_BURST;
                end
            end
            ST_BURST: begin
                rsp_valid = 1'b1;
                rsp_data  = mem_rdata;
                rsp_idx   = beat_q;
                rsp_last  = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
                if (bus.rsp_ready) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (rsp_last) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WACK: begin
                rsp_valid = 1'b1;
                rsp_data  = wdata_q;
                rsp_idx   = off_q;
                rsp_last  = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_idx   = rsp_idx;
    assign bus.rsp_last  = rsp_last;

endmodule

// File: tb/tb_dm_line_fill_mem.sv
// Bench for dm_line_fill_mem: directed cases then randomized reads/writes
// checked against a word-array model of the backing store.
module tb_dm_line_fill_mem;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] model_mem [DEPTH];

    dm_line_fill_mem_if #(.ADDR_W(32), .DATA_W(32), .IDX_W(2)) bus ();

    dm_line_fill_mem #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .WORDS_PER_LINE (4),
        .LATENCY        (LAT),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int line_base(input logic [31:0] a);
        return word_idx(a) - (word_idx(a) % 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // Waits for the first response beat; returns 0 if it never came.
    task automatic wait_rsp(input string tag, input bit toggle, output bit ok);
        int edges;
        edges = 0;
        while (!bus.rsp_valid && edges < 50) begin
            if (toggle) scramble_req();
            @(negedge clk);
            edges++;
        end
        check({tag, ".latency"}, edges, LAT);
        ok = bus.rsp_valid;
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag, input int stall_beat,
                           input int stall_cycles, input bit toggle, input int abort_beat);
        int base;
        bit ok;
        base = line_base(addr);
        check({tag, ".ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = addr;
        bus.req_wdata = $urandom;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, ".ready_busy"}, bus.req_ready, 0);
        wait_rsp(tag, toggle, ok);
        if (!ok) begin
            bus.req_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (k == abort_beat) begin
                #2 rst_n = 1'b0;
                #1;
                check({tag, ".abort_valid"}, bus.rsp_valid, 0);
                check({tag, ".abort_data"}, bus.rsp_data, 0);
                check({tag, ".abort_ready"}, bus.req_ready, 0);
                @(negedge clk);
                rst_n = 1'b1;
                bus.req_valid = 1'b0;
                #1;
                check({tag, ".post_reset_ready"}, bus.req_ready, 1);
                return;
            end
            check({tag, ".valid"}, bus.rsp_valid, 1);
            check({tag, ".data"}, bus.rsp_data, model_mem[base + k]);
            check({tag, ".idx"}, bus.rsp_idx, k);
            check({tag, ".last"}, bus.rsp_last, (k == 3));
            if (k == stall_beat && stall_cycles > 0) begin
                bus.rsp_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    if (toggle) scramble_req();
                    @(negedge clk);
                    check({tag, ".stall_data"}, bus.rsp_data, model_mem[base + k]);
                    check({tag, ".stall_idx"}, bus.rsp_idx, k);
                end
                bus.rsp_ready = 1'b1;
            end
            if (toggle && k < 3) scramble_req();
            else bus.req_valid = 1'b0;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check({tag, ".done_valid"}, bus.rsp_valid, 0);
        check({tag, ".done_ready"}, bus.req_ready, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        bit ok;
        check({tag, ".ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        model_mem[word_idx(addr)] = data;
        check({tag, ".ready_busy"}, bus.req_ready, 0);
        wait_rsp(tag, 1'b0, ok);
        if (!ok) return;
        check({tag, ".data"}, bus.rsp_data, data);
        check({tag, ".idx"}, bus.rsp_idx, word_idx(addr) % 4);
        check({tag, ".last"}, bus.rsp_last, 1);
        @(negedge clk);
        check({tag, ".done_valid"}, bus.rsp_valid, 0);
        check({tag, ".done_ready"}, bus.req_ready, 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(4 * i);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        #1;
        check("rst.req_ready", bus.req_ready, 0);
        check("rst.rsp_valid", bus.rsp_valid, 0);
        check("rst.rsp_data", bus.rsp_data, 0);
        check("rst.rsp_idx", bus.rsp_idx, 0);
        check("rst.rsp_last", bus.rsp_last, 0);
        repeat (3) @(negedge clk);
        check("rst.req_ready_held", bus.req_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rst.req_ready_after", bus.req_ready, 1);

        do_read(32'h0000_0014, "read14", -1, 0, 1'b0, -1);
        do_read(32'h0020_0016, "alias", -1, 0, 1'b0, -1);
        do_write(32'h0000_0014, 32'hDEAD_BEEF, "write14");
        do_read(32'h0000_0010, "raw10", -1, 0, 1'b0, -1);
        do_read(32'h0000_0040, "bp40", 2, 5, 1'b0, -1);
        do_read(32'h0000_0040, "abort40", -1, 0, 1'b0, 2);
        do_read(32'h0000_0040, "reread40", -1, 0, 1'b0, -1);
        do_read(32'h0000_0080, "toggle80", 1, 2, 1'b1, -1);
        repeat (3) begin
            @(negedge clk);
            check("toggle80.quiet", bus.rsp_valid, 0);
        end

        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom;
                do_write(a, d, "rnd_wr");
            end else begin
                do_read(a, "rnd_rd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
